// File: rtl/morse_collect_symbols.sv
// Times marks/spaces on ce ticks, packs dit/dah symbols per character and strobes
// valid on character and word gaps. Define MORSE_LONG_MARK_ERR_EN to flag overlong marks.
module morse_collect_symbols #(
  parameter int DAH_TICKS      = 3,
  parameter int CHAR_GAP_TICKS = 3,
  parameter int WORD_GAP_TICKS = 7,
  parameter int MAX_MARK_TICKS = 15,
  parameter int CNT_W          = 8,
  parameter int MAX_MORSE_LEN  = 5,
  parameter int MORSE_LEN_W    = $clog2(MAX_MORSE_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     aclr_n,
  input  logic                     ce,
  input  logic                     key,
  output logic                     valid,
  output logic [MAX_MORSE_LEN-1:0] dits_dahs,
  output logic [MORSE_LEN_W-1:0]   len,
  output logic                     word_end,
  output logic                     error
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, WAIT_WORD} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [MAX_MORSE_LEN-1:0] sh_q, sh_d, dd_q, dd_d;
  logic [MORSE_LEN_W-1:0]   n_q, n_d, len_q, len_d;
  logic                     err_q, err_d, valid_q, valid_d;
  logic                     we_q, we_d, error_q, error_d;
  logic                     sym;

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign sym     = (cnt_q >= CNT_W'(DAH_TICKS));

`ifndef MORSE_LONG_MARK_ERR_EN
  logic unused_max_mark;
  assign unused_max_mark = ^MAX_MARK_TICKS;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    n_d     = n_q;
    err_d   = err_q;
    valid_d = 1'b0;
    dd_d    = dd_q;
    len_d   = len_q;
    we_d    = we_q;
    error_d = error_q;
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (key) begin
            state_d = MARK;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = cnt_inc;
          end
        end
        MARK: begin
          if (key) begin
            cnt_d = cnt_inc;
`ifdef MORSE_LONG_MARK_ERR_EN
            if (cnt_inc >= CNT_W'(MAX_MARK_TICKS)) err_d = 1'b1;
`endif
          end else begin
            // Symbols beyond capacity are dropped but poison the character.
            if (n_q < MORSE_LEN_W'(MAX_MORSE_LEN)) begin
              sh_d = (sh_q << 1) | MAX_MORSE_LEN'(sym);
              n_d  = n_q + MORSE_LEN_W'(1);
            end else begin
              err_d = 1'b1;
            end
            cnt_d   = CNT_W'(1);
            state_d = SPACE;
          end
        end
        SPACE: begin
          if (key) begin
            state_d = MARK;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(CHAR_GAP_TICKS)) begin
              dd_d    = sh_q;
              len_d   = n_q;
              error_d = err_q;
              we_d    = 1'b0;
              valid_d = 1'b1;
              sh_d    = '0;
              n_d     = '0;
              err_d   = 1'b0;
              state_d = WAIT_WORD;
            end
          end
        end
        WAIT_WORD: begin
          if (key) begin
            state_d = MARK;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(WORD_GAP_TICKS)) begin
              we_d    = 1'b1;
              valid_d = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      n_q     <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      dd_q    <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      n_q     <= n_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      dd_q    <= dd_d;
      len_q   <= len_d;
      we_q    <= we_d;
      error_q <= error_d;
    end
  end

  assign valid     = valid_q;
  assign dits_dahs = dd_q;
  assign len       = len_q;
  assign word_end  = we_q;
  assign error     = error_q;

endmodule
